bpsk_demod_rx: RTL and testbench



---
 rtl/bpsk_pkg.sv | 24 ++
 rtl/bpsk_demod_rx_if.sv | 37 +++
 rtl/bpsk_demod_rx_bit_packer.sv | 87 ++++++++
 rtl/bpsk_demod_rx.sv | 144 ++++++++++++++
 tb/tb_bpsk_demod_rx.sv | 392 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bpsk_pkg.sv
// rtl/bpsk_pkg.sv - shared BPSK mapping constants, clog2 helper and receiver FSM states
//
// Shared by the BPSK modulator and the bpsk_demod_rx receiver.
//   BPSK_POS / BPSK_NEG : real-rail levels for bit 1 / bit 0
//   rx_state_t          : receiver FSM states
//   clog2               : ceil(log2(n)), returns 0 for n <= 1
package bpsk_pkg;

  localparam logic signed [15:0] BPSK_POS = 16'sh7FFF;
  localparam logic signed [15:0] BPSK_NEG = 16'sh8001;

  typedef enum logic {
    IDLE  = 1'b0,
    INTEG = 1'b1
  } rx_state_t;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/bpsk_demod_rx_if.sv
// rtl/bpsk_demod_rx_if.sv - sample, bit and word signal bundle of the BPSK receiver
//
// Signals (slave = receiver side):
//   en, sync                 control inputs of the receiver
//   sample_re/im, sample_valid  complex baseband sample stream
//   bit_out, bit_valid, bit_weak  sliced bit stream
//   word_out, word_valid, word_ready  packed word handshake
//   overflow                 sticky lost-word flag
interface bpsk_demod_rx_if #(
  parameter int DATA_W    = 16,
  parameter int WORD_BITS = 8
);

  logic                        en;
  logic                        sync;
  logic signed [DATA_W-1:0]    sample_re;
  logic signed [DATA_W-1:0]    sample_im;
  logic                        sample_valid;
  logic                        bit_out;
  logic                        bit_valid;
  logic                        bit_weak;
  logic        [WORD_BITS-1:0] word_out;
  logic                        word_valid;
  logic                        word_ready;
  logic                        overflow;

  modport master (
    output en, sync, sample_re, sample_im, sample_valid, word_ready,
    input  bit_out, bit_valid, bit_weak, word_out, word_valid, overflow
  );

  modport slave (
    input  en, sync, sample_re, sample_im, sample_valid, word_ready,
    output bit_out, bit_valid, bit_weak, word_out, word_valid, overflow
  );

endinterface

// File: rtl/bpsk_demod_rx_bit_packer.sv
// rtl/bpsk_demod_rx_bit_packer.sv - MSB-first bit packer with one-word holding register
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   bit_in        bit to pack (shifted in at the LSB)
//   bit_in_valid  bit_in qualifier
//   clear         drop the partial word (shift register and bit count)
//   ovf_clear     clear the sticky overflow flag
//   word_out      held word, first received bit in the MSB
//   word_valid    holding register full
//   word_ready    downstream accept
//   overflow      sticky: a completed word found the holding register busy
module bit_packer
  import bpsk_pkg::*;
#(
  parameter int WORD_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bit_in,
  input  logic                 bit_in_valid,
  input  logic                 clear,
  input  logic                 ovf_clear,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 overflow
);

  localparam int BC_W = clog2(WORD_BITS) + 1;
  localparam logic [BC_W-1:0] FULL_CNT = BC_W'(WORD_BITS);

  logic [WORD_BITS-1:0] shift_q;
  logic [WORD_BITS-1:0] shift_base;
  logic [WORD_BITS-1:0] shift_next;
  logic [BC_W-1:0]      cnt_q;
  logic [BC_W-1:0]      cnt_base;
  logic [BC_W-1:0]      cnt_next;
  logic                 word_done;
  logic                 can_load;

  // A clear in the same cycle as a bit makes that bit the first of a new word.
  always_comb begin
    shift_base = clear ? '0 : shift_q;
    cnt_base   = clear ? '0 : cnt_q;
    shift_next = (shift_base << 1) | WORD_BITS'(bit_in);
    cnt_next   = cnt_base + BC_W'(1);
    word_done  = bit_in_valid && (cnt_next == FULL_CNT);
    can_load   = !word_valid || word_ready;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q    <= '0;
      cnt_q      <= '0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (word_done) begin
        shift_q <= '0;
        cnt_q   <= '0;
      end else if (bit_in_valid) begin
        shift_q <= shift_next;
        cnt_q   <= cnt_next;
      end else begin
        shift_q <= shift_base;
        cnt_q   <= cnt_base;
      end

      // Accept and load in the same cycle keeps word_valid high with new data.
      if (word_done && can_load) begin
        word_out   <= shift_next;
        word_valid <= 1'b1;
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      if (ovf_clear) begin
        overflow <= 1'b0;
      end else if (word_done && !can_load) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bpsk_demod_rx.sv
// rtl/bpsk_demod_rx.sv - BPSK baseband receiver: integrate-and-dump slicer plus word packer
//
// Ports:
//   clk   system clock
//   rst   asynchronous active-high reset
//   bus   bpsk_demod_rx_if.slave:
//         en (low = IDLE), sync (realign strobe, clears overflow),
//         sample_re/sample_im/sample_valid in, bit_out/bit_valid/bit_weak out,
//         word_out/word_valid/word_ready handshake, overflow sticky flag
module bpsk_demod_rx
  import bpsk_pkg::*;
#(
  parameter int          DATA_W      = 16,
  parameter int          SPS         = 4,
  parameter int          WORD_BITS   = 8,
  parameter int unsigned WEAK_THRESH = 1024
) (
  input logic            clk,
  input logic            rst,
  bpsk_demod_rx_if.slave bus
);

  localparam int ACC_W = DATA_W + clog2(SPS);
  localparam int CNT_W = (clog2(SPS) > 0) ? clog2(SPS) : 1;
  localparam logic [CNT_W-1:0] LAST_SAMP = CNT_W'(SPS - 1);

  rx_state_t state_q;
  rx_state_t state_d;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_base;
  logic signed [ACC_W-1:0] acc_next;
  logic signed [ACC_W:0]   acc_ext;
  logic        [ACC_W:0]   acc_mag;
  logic [CNT_W-1:0]        cnt_q;
  logic [CNT_W-1:0]        cnt_base;
  logic                    integ_active;
  logic                    take;
  logic                    dump;
  logic                    slice_bit;
  logic                    slice_weak;

  logic                    bit_q;
  logic                    bit_valid_q;
  logic                    bit_weak_q;

  logic [WORD_BITS-1:0]    pk_word;
  logic                    pk_valid;
  logic                    pk_overflow;

  // Imag rail is carried only for pin compatibility with the modulator.
  logic unused_im;
  assign unused_im = ^bus.sample_im;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.en)  state_d = INTEG;
      INTEG:   if (!bus.en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Samples are only taken while integrating with en still high, so the cycle
  // en drops already discards input.
  always_comb begin
    integ_active = (state_q == INTEG) && bus.en;
    take         = integ_active && bus.sample_valid;
    acc_base     = bus.sync ? '0 : acc_q;
    cnt_base     = bus.sync ? '0 : cnt_q;
    acc_next     = acc_base + ACC_W'($signed(bus.sample_re));
    dump         = take && (cnt_base == LAST_SAMP);
    // One extra bit so the most negative sum has a representable magnitude.
    acc_ext      = {acc_next[ACC_W-1], acc_next};
    acc_mag      = acc_next[ACC_W-1] ? unsigned'(-acc_ext) : unsigned'(acc_ext);
    slice_bit    = ~acc_next[ACC_W-1];
    slice_weak   = 32'(acc_mag) < WEAK_THRESH;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (!integ_active) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (take) begin
      if (dump) begin
        acc_q <= '0;
        cnt_q <= '0;
      end else begin
        acc_q <= acc_next;
        cnt_q <= cnt_base + CNT_W'(1);
      end
    end else if (bus.sync) begin
      acc_q <= '0;
      cnt_q <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_q       <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_weak_q  <= 1'b0;
    end else begin
      bit_valid_q <= dump;
      if (dump) begin
        bit_q      <= slice_bit;
        bit_weak_q <= slice_weak;
      end
    end
  end

  // The packer sees the bit in the dump cycle so a completed word is presented
  // together with the bit_valid pulse of its last bit.
  bit_packer #(
    .WORD_BITS (WORD_BITS)
  ) u_packer (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (slice_bit),
    .bit_in_valid (dump),
    .clear        (bus.sync || !integ_active),
    .ovf_clear    (bus.sync),
    .word_out     (pk_word),
    .word_valid   (pk_valid),
    .word_ready   (bus.word_ready),
    .overflow     (pk_overflow)
  );

  assign bus.bit_out    = bit_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.bit_weak   = bit_weak_q;
  assign bus.word_out   = pk_word;
  assign bus.word_valid = pk_valid;
  assign bus.overflow   = pk_overflow;

endmodule

// File: tb/tb_bpsk_demod_rx.sv
// tb/tb_bpsk_demod_rx.sv - self-checking bench for bpsk_demod_rx
module tb_bpsk_demod_rx;

  localparam int SPS = 4;
  localparam int WB  = 8;
  localparam int AMP = 8000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  bpsk_demod_rx_if #(.DATA_W(16), .WORD_BITS(WB)) bus ();

  bpsk_demod_rx #(
    .DATA_W      (16),
    .SPS         (SPS),
    .WORD_BITS   (WB),
    .WEAK_THRESH (1024)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit          obs_bits[$];
  bit          obs_weak[$];
  logic [WB-1:0] obs_words[$];
  int          wv_cycles;

  task automatic clear_obs();
    obs_bits.delete();
    obs_weak.delete();
    obs_words.delete();
    wv_cycles = 0;
  endtask

  // Inputs are set at edge+1; transfers are seen just before the edge,
  // registered outputs 1 time unit after it.
  task automatic tick();
    if (bus.word_valid && bus.word_ready) obs_words.push_back(bus.word_out);
    @(posedge clk);
    #1;
    if (bus.bit_valid) begin
      obs_bits.push_back(bus.bit_out);
      obs_weak.push_back(bus.bit_weak);
    end
    if (bus.word_valid) wv_cycles++;
  endtask

  task automatic send_one(input int re, input int gap, input bit sync_now);
    bus.sample_re    = 16'(re);
    bus.sample_im    = 16'($urandom);
    bus.sample_valid = 1'b1;
    bus.sync         = sync_now;
    tick();
    bus.sample_valid = 1'b0;
    bus.sync         = 1'b0;
    for (int g = 0; g < gap; g++) begin
      bus.sample_re = 16'($urandom);
      tick();
    end
  endtask

  task automatic send_symbol(input int amp, input int gap, input bit sync_first, input bit ready_last);
    for (int i = 0; i < SPS; i++) begin
      if (ready_last && i == SPS - 1) bus.word_ready = 1'b1;
      send_one(amp, gap, sync_first && i == 0);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input bit sync_first, input bit ready_last);
    for (int k = 7; k >= 0; k--)
      send_symbol(b[k] ? AMP : -AMP, gap, sync_first && k == 7, ready_last && k == 0);
  endtask

  task automatic flush();
    bus.sample_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic start_rx(input bit ready);
    bus.word_ready = ready;
    bus.en   = 1'b0;
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    bus.en   = 1'b1;
    tick();
    clear_obs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en = 1'b0; bus.sync = 1'b0; bus.sample_valid = 1'b0;
    bus.sample_re = '0; bus.sample_im = '0; bus.word_ready = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({bus.bit_out, bus.bit_valid, bus.bit_weak, bus.word_valid, bus.overflow} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b expected 00000",
               {bus.bit_out, bus.bit_valid, bus.bit_weak, bus.word_valid, bus.overflow});
    end
    n_checks++;
    if (bus.word_out !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_word: got %h expected 00", bus.word_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_pattern();
    bit exp_bits[8] = '{1, 0, 1, 1, 0, 0, 1, 0};
    start_rx(1'b1);
    for (int i = 0; i < 8; i++) send_symbol(exp_bits[i] ? AMP : -AMP, 0, 1'b0, 1'b0);
    flush();
    n_checks++;
    if (obs_bits.size() !== 8) begin
      n_fail++;
      $display("FAIL pattern_bit_count: got %0d expected 8", obs_bits.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (obs_bits[i] !== exp_bits[i] || obs_weak[i] !== 1'b0) begin
          n_fail++;
          $display("FAIL pattern_bit%0d: got bit %b weak %b expected bit %b weak 0",
                   i, obs_bits[i], obs_weak[i], exp_bits[i]);
        end
      end
    end
    n_checks++;
    if (obs_words.size() !== 1 || obs_words[0] !== 8'hB2) begin
      n_fail++;
      $display("FAIL pattern_word: got %0d words first %h expected 1 word B2",
               obs_words.size(), obs_words.size() > 0 ? obs_words[0] : 8'hxx);
    end
    n_checks++;
    if (wv_cycles !== 1) begin
      n_fail++;
      $display("FAIL pattern_word_valid_pulse: got %0d cycles expected 1", wv_cycles);
    end
  endtask

  task automatic test_weak();
    start_rx(1'b1);
    send_symbol(100, 0, 1'b0, 1'b0);                 // sum 400: weak 1
    send_one(100, 0, 0); send_one(-100, 0, 0);       // sum 0: slices to 1, weak
    send_one(200, 1, 0); send_one(-200, 0, 0);
    send_one(255, 0, 0); send_one(256, 0, 0);        // sum 1023: still weak
    send_one(256, 0, 0); send_one(256, 0, 0);
    send_symbol(256, 0, 1'b0, 1'b0);                 // sum 1024: not weak
    send_symbol(-256, 0, 1'b0, 1'b0);                // sum -1024: bit 0, not weak
    send_one(-255, 0, 0); send_one(-256, 0, 0);      // sum -1023: bit 0, weak
    send_one(-256, 0, 0); send_one(-256, 0, 0);
    flush();
    begin
      bit eb[6] = '{1, 1, 1, 1, 0, 0};
      bit ew[6] = '{1, 1, 1, 0, 0, 1};
      n_checks++;
      if (obs_bits.size() !== 6) begin
        n_fail++;
        $display("FAIL weak_bit_count: got %0d expected 6", obs_bits.size());
      end else begin
        for (int i = 0; i < 6; i++) begin
          n_checks++;
          if (obs_bits[i] !== eb[i] || obs_weak[i] !== ew[i]) begin
            n_fail++;
            $display("FAIL weak_sym%0d: got bit %b weak %b expected bit %b weak %b",
                     i, obs_bits[i], obs_weak[i], eb[i], ew[i]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    start_rx(1'b0);
    send_byte(8'hA5, 0, 1'b0, 1'b0);
    send_byte(8'h3C, 0, 1'b0, 1'b0);
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hA5 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got valid %b word %h ovf %b expected valid 1 word A5 ovf 1",
               bus.word_valid, bus.word_out, bus.overflow);
    end
    bus.word_ready = 1'b1;
    tick();
    n_checks++;
    if (bus.word_valid !== 1'b0 || obs_words.size() !== 1 || obs_words[0] !== 8'hA5) begin
      n_fail++;
      $display("FAIL bp_accept: got valid %b words %0d expected valid 0 one word A5",
               bus.word_valid, obs_words.size());
    end
    n_checks++;
    if (bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_sticky: got ovf %b expected 1", bus.overflow);
    end
    bus.sync = 1'b1;
    tick();
    bus.sync = 1'b0;
    n_checks++;
    if (bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_sync_clear: got ovf %b expected 0", bus.overflow);
    end
  endtask

  task automatic test_back_to_back();
    start_rx(1'b0);
    send_byte(8'hA5, 0, 1'b0, 1'b0);
    send_byte(8'h3C, 0, 1'b0, 1'b1);
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'h3C || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_load: got valid %b word %h ovf %b expected valid 1 word 3C ovf 0",
               bus.word_valid, bus.word_out, bus.overflow);
    end
    flush();
    n_checks++;
    if (obs_words.size() !== 2 || obs_words[0] !== 8'hA5 || obs_words[1] !== 8'h3C) begin
      n_fail++;
      $display("FAIL b2b_words: got %0d words expected A5,3C", obs_words.size());
    end
  endtask

  task automatic test_sync();
    bit eb[11] = '{1, 1, 1, 1, 0, 0, 1, 0, 1, 1, 0};
    for (int gap = 0; gap <= 2; gap += 2) begin
      start_rx(1'b1);
      for (int s = 0; s < 3; s++) send_symbol(AMP, gap, 1'b0, 1'b0);
      send_one(-AMP, gap, 0);
      send_one(-AMP, gap, 0);
      send_byte(8'h96, gap, 1'b1, 1'b0);
      flush();
      n_checks++;
      if (obs_bits.size() !== 11) begin
        n_fail++;
        $display("FAIL sync_bit_count_gap%0d: got %0d expected 11", gap, obs_bits.size());
      end else begin
        for (int i = 0; i < 11; i++) begin
          n_checks++;
          if (obs_bits[i] !== eb[i]) begin
            n_fail++;
            $display("FAIL sync_bit%0d_gap%0d: got %b expected %b", i, gap, obs_bits[i], eb[i]);
          end
        end
      end
      n_checks++;
      if (obs_words.size() !== 1 || obs_words[0] !== 8'h96) begin
        n_fail++;
        $display("FAIL sync_word_gap%0d: got %0d words expected one word 96", gap, obs_words.size());
      end
    end
  endtask

  task automatic test_reset_en();
    start_rx(1'b0);
    send_byte(8'h5A, 0, 1'b0, 1'b0);
    send_byte(8'h11, 0, 1'b0, 1'b0);
    send_one(AMP, 0, 0);
    send_one(AMP, 0, 0);
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.overflow !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_precond: got valid %b ovf %b expected 1 1", bus.word_valid, bus.overflow);
    end
    #3 rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.bit_out, bus.bit_valid, bus.bit_weak, bus.word_valid, bus.overflow, bus.word_out} !== 13'b0) begin
      n_fail++;
      $display("FAIL rst_async: got %b expected all zero",
               {bus.bit_out, bus.bit_valid, bus.bit_weak, bus.word_valid, bus.overflow, bus.word_out});
    end
    @(posedge clk);
    #1 rst = 1'b0;
    start_rx(1'b1);
    send_byte(8'hE7, 0, 1'b0, 1'b0);
    flush();
    n_checks++;
    if (obs_words.size() !== 1 || obs_words[0] !== 8'hE7) begin
      n_fail++;
      $display("FAIL rst_resume: got %0d words expected one word E7", obs_words.size());
    end

    start_rx(1'b0);
    send_byte(8'hC3, 0, 1'b0, 1'b0);
    send_symbol(AMP, 0, 1'b0, 1'b0);
    send_symbol(-AMP, 0, 1'b0, 1'b0);
    send_symbol(AMP, 0, 1'b0, 1'b0);
    bus.en = 1'b0;
    send_symbol(AMP, 0, 1'b0, 1'b0);
    n_checks++;
    if (bus.word_valid !== 1'b1 || bus.word_out !== 8'hC3) begin
      n_fail++;
      $display("FAIL en_hold: got valid %b word %h expected valid 1 word C3",
               bus.word_valid, bus.word_out);
    end
    bus.en = 1'b1;
    bus.word_ready = 1'b1;
    tick();
    send_byte(8'h0F, 0, 1'b0, 1'b0);
    flush();
    n_checks++;
    if (obs_words.size() !== 2 || obs_words[0] !== 8'hC3 || obs_words[1] !== 8'h0F
        || bus.overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL en_discard: got %0d words ovf %b expected C3,0F ovf 0",
               obs_words.size(), bus.overflow);
    end
  endtask

  task automatic test_random();
    localparam int NSYM = 48;
    bit            exp_bit[$];
    bit            exp_weak[$];
    logic [WB-1:0] exp_word[$];
    start_rx(1'b1);
    for (int s = 0; s < NSYM; s++) begin
      int sum;
      int smp[SPS];
      sum = 0;
      if ($urandom_range(0, 7) == 0) begin
        int a;
        a = int'($urandom_range(0, 20000)) - 10000;
        for (int i = 0; i < SPS; i++) smp[i] = (i % 2 == 0) ? a : -a;
      end else begin
        int bias;
        bias = int'($urandom_range(0, 3000)) * ($urandom_range(0, 1) ? 1 : -1);
        for (int i = 0; i < SPS; i++) smp[i] = bias + int'($urandom_range(0, 4000)) - 2000;
      end
      for (int i = 0; i < SPS; i++) begin
        sum += smp[i];
        send_one(smp[i], int'($urandom_range(0, 2)), 0);
      end
      exp_bit.push_back(sum >= 0);
      exp_weak.push_back(((sum < 0) ? -sum : sum) < 1024);
    end
    flush();
    for (int w = 0; w < NSYM / WB; w++) begin
      logic [WB-1:0] v;
      v = '0;
      for (int k = 0; k < WB; k++) v = (v << 1) | WB'(exp_bit[w * WB + k]);
      exp_word.push_back(v);
    end
    n_checks++;
    if (obs_bits.size() !== NSYM) begin
      n_fail++;
      $display("FAIL rand_bit_count: got %0d expected %0d", obs_bits.size(), NSYM);
    end else begin
      for (int i = 0; i < NSYM; i++) begin
        n_checks++;
        if (obs_bits[i] !== exp_bit[i] || obs_weak[i] !== exp_weak[i]) begin
          n_fail++;
          $display("FAIL rand_sym%0d: got bit %b weak %b expected bit %b weak %b",
                   i, obs_bits[i], obs_weak[i], exp_bit[i], exp_weak[i]);
        end
      end
    end
    n_checks++;
    if (obs_words.size() !== exp_word.size()) begin
      n_fail++;
      $display("FAIL rand_word_count: got %0d expected %0d", obs_words.size(), exp_word.size());
    end else begin
      for (int w = 0; w < exp_word.size(); w++) begin
        n_checks++;
        if (obs_words[w] !== exp_word[w]) begin
          n_fail++;
          $display("FAIL rand_word%0d: got %h expected %h", w, obs_words[w], exp_word[w]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pattern();
    test_weak();
    test_backpressure();
    test_back_to_back();
    test_sync();
    test_reset_en();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
